orv64_int_scheduler: RTL and testbench



---
 rtl/orv64_int_scheduler.sv | 141 ++++++++++++++
 tb/tb_orv64_int_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/orv64_int_scheduler.sv
// ============================================================================
// orv64_int_scheduler: picks one eligible interrupt from mip & mie and offers it
// to the trap pipeline over a valid/ready handshake.  Rev 1.0
// ============================================================================
`default_nettype none

package orv64_int_pkg;
  typedef logic [11:0] orv64_csr_ideleg_t;
  typedef logic [3:0]  orv64_int_cause_t;
endpackage

module orv64_int_scheduler
  import orv64_int_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       mip,
  input  logic [11:0]       mie,
  input  orv64_csr_ideleg_t ideleg,
  input  logic [1:0]        prv,
  input  logic              mstatus_mie,
  input  logic              mstatus_sie,
  input  logic              debug_mode,
  input  logic              int_req_ready,
  output logic              int_req_valid,
  output orv64_int_cause_t  int_req_cause,
  output logic              int_req_to_s,
  output logic              int_pending_any
);

  localparam int CNT_W = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int TO_LAST_I = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam bit TO_EN = (ACK_TIMEOUT != 0);
  // Only MSI/MTI/MEI and SSI/STI/SEI are implemented; U-level and reserved bits drop out.
  localparam logic [11:0] IMPL_MASK = 12'hAAA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  orv64_int_cause_t    cause_q, cause_d;
  logic                to_s_q, to_s_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [11:0]         cand;
  logic [11:0]         elig;
  logic [15:0]         elig_ext;
  logic                m_ok;
  logic                s_ok;
  logic                win_valid;
  orv64_int_cause_t    win_cause;
  logic                cur_elig;

  assign cand = mip & mie & IMPL_MASK;
  assign m_ok = (prv != 2'd3) || mstatus_mie;
  assign s_ok = (prv == 2'd0) || ((prv == 2'd1) && mstatus_sie);

  always_comb begin
    for (int i = 0; i < 12; i++) begin
      elig[i] = cand[i] & (ideleg[i] ? s_ok : m_ok);
    end
  end

  assign elig_ext        = {4'b0000, elig};
  assign cur_elig        = elig_ext[cause_q];
  assign int_pending_any = |elig;

  always_comb begin
    win_valid = 1'b1;
    win_cause = 4'd0;
    if (elig[11])     win_cause = 4'd11;
    else if (elig[3]) win_cause = 4'd3;
    else if (elig[7]) win_cause = 4'd7;
    else if (elig[9]) win_cause = 4'd9;
    else if (elig[1]) win_cause = 4'd1;
    else if (elig[5]) win_cause = 4'd5;
    else              win_valid = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    to_s_d  = to_s_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_valid && !debug_mode) begin
          state_d = S_REQ;
          cause_d = win_cause;
          to_s_d  = ideleg[win_cause];
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        // A handshake in the same cycle as losing eligibility still counts.
        if (int_req_ready) begin
          state_d = S_HOLD;
        end else if (!cur_elig || debug_mode) begin
          state_d = S_IDLE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = S_IDLE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      to_s_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      to_s_q  <= to_s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign int_req_valid = (state_q == S_REQ);
  assign int_req_cause = cause_q;
  assign int_req_to_s  = to_s_q;

endmodule

`default_nettype wire

// File: tb/tb_orv64_int_scheduler.sv
// ============================================================================
// tb_orv64_int_scheduler: directed self-checking bench for orv64_int_scheduler.
// ============================================================================
`default_nettype none

module tb_orv64_int_scheduler;
  import orv64_int_pkg::*;

  logic              clk;
  logic              rst;
  logic [11:0]       mip;
  logic [11:0]       mie;
  orv64_csr_ideleg_t ideleg;
  logic [1:0]        prv;
  logic              mstatus_mie;
  logic              mstatus_sie;
  logic              debug_mode;
  logic              ready;
  logic              ready4;

  logic              valid, to_s, pend;
  orv64_int_cause_t  cause;
  logic              valid4, to_s4, pend4;
  orv64_int_cause_t  cause4;

  int checks = 0;
  int errors = 0;

  orv64_int_scheduler u_dut (
    .clk(clk), .rst(rst), .mip(mip), .mie(mie), .ideleg(ideleg), .prv(prv),
    .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie), .debug_mode(debug_mode),
    .int_req_ready(ready), .int_req_valid(valid), .int_req_cause(cause),
    .int_req_to_s(to_s), .int_pending_any(pend)
  );

  orv64_int_scheduler #(.ACK_TIMEOUT(4)) u_dut_t4 (
    .clk(clk), .rst(rst), .mip(mip), .mie(mie), .ideleg(ideleg), .prv(prv),
    .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie), .debug_mode(debug_mode),
    .int_req_ready(ready4), .int_req_valid(valid4), .int_req_cause(cause4),
    .int_req_to_s(to_s4), .int_pending_any(pend4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mip = '0; mie = '0; ideleg = '0; prv = 2'd0;
    mstatus_mie = 1'b0; mstatus_sie = 1'b0; debug_mode = 1'b0;
    ready = 1'b0; ready4 = 1'b0;
    #2;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_to_s",  32'(to_s),  32'd0);
    chk("rst_pend",  32'(pend),  32'd0);

    // MTI with ready tied high
    mip[7] = 1'b1; mie[7] = 1'b1; ready = 1'b1;
    #1;
    chk("mti_pend", 32'(pend), 32'd1);
    tick();
    chk("mti_valid", 32'(valid), 32'd1);
    chk("mti_cause", 32'(cause), 32'd7);
    chk("mti_to_s",  32'(to_s),  32'd0);
    tick();
    chk("mti_hold", 32'(valid), 32'd0);
    tick();
    chk("mti_idle", 32'(valid), 32'd0);
    tick();
    chk("mti_rereq", 32'(valid), 32'd1);
    // withdraw: pending bit cleared while ready low
    mip[7] = 1'b0; ready = 1'b0;
    tick();
    chk("wd_valid", 32'(valid), 32'd0);
    tick();

    // MEI/SEI/MSI at M-mode
    mip = 12'h0; mie = 12'h0;
    mip[11] = 1'b1; mip[9] = 1'b1; mip[3] = 1'b1;
    mie[11] = 1'b1; mie[9] = 1'b1; mie[3] = 1'b1;
    prv = 2'd3; mstatus_mie = 1'b1;
    tick();
    chk("mei_valid", 32'(valid), 32'd1);
    chk("mei_cause", 32'(cause), 32'd11);
    tick(); tick(); tick();
    chk("mei_stable_valid", 32'(valid), 32'd1);
    chk("mei_stable_cause", 32'(cause), 32'd11);
    ready = 1'b1;
    tick();
    chk("mei_xfer", 32'(valid), 32'd0);
    mip[11] = 1'b0; ready = 1'b0;
    tick();
    chk("mei_hold_idle", 32'(valid), 32'd0);
    tick();
    chk("msi_valid", 32'(valid), 32'd1);
    chk("msi_cause", 32'(cause), 32'd3);
    mip = 12'h0; mie = 12'h0;
    tick(); tick();

    // Delegated SSI blocked in M-mode, taken from S-mode with SIE
    ideleg[1] = 1'b1; mip[1] = 1'b1; mie[1] = 1'b1;
    prv = 2'd3; mstatus_mie = 1'b1; mstatus_sie = 1'b1;
    #1;
    chk("ssi_m_pend", 32'(pend), 32'd0);
    tick();
    chk("ssi_m_valid", 32'(valid), 32'd0);
    prv = 2'd1;
    #1;
    chk("ssi_s_pend", 32'(pend), 32'd1);
    tick();
    chk("ssi_s_valid", 32'(valid), 32'd1);
    chk("ssi_s_cause", 32'(cause), 32'd1);
    chk("ssi_s_to_s",  32'(to_s),  32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0; mip = 12'h0; mie = 12'h0; ideleg = '0; prv = 2'd0;
    tick(); tick(); tick();
    chk("quiet_main", 32'(valid), 32'd0);
    chk("quiet_t4",   32'(valid4), 32'd0);

    // Timeout instance: MTI held with ready low, MEI arrives mid-request
    mip[7] = 1'b1; mie[7] = 1'b1;
    tick();
    chk("to_v1", 32'(valid4), 32'd1);
    chk("to_c1", 32'(cause4), 32'd7);
    tick();
    chk("to_v2", 32'(valid4), 32'd1);
    mip[11] = 1'b1; mie[11] = 1'b1;
    tick();
    chk("to_v3", 32'(valid4), 32'd1);
    chk("to_nopreempt", 32'(cause4), 32'd7);
    tick();
    chk("to_v4", 32'(valid4), 32'd1);
    tick();
    chk("to_drop", 32'(valid4), 32'd0);
    chk("main_no_to", 32'(valid), 32'd1);
    tick();
    chk("to_rereq", 32'(valid4), 32'd1);
    chk("to_rereq_cause", 32'(cause4), 32'd11);
    ready = 1'b1; ready4 = 1'b1;
    tick();
    ready = 1'b0; ready4 = 1'b0; mip = 12'h0; mie = 12'h0;
    tick(); tick(); tick();

    // Handshake wins over simultaneous loss of eligibility
    mip[7] = 1'b1; mie[7] = 1'b1;
    tick();
    chk("hs_valid", 32'(valid), 32'd1);
    mip[7] = 1'b0; ready = 1'b1;
    tick();
    chk("hs_drop", 32'(valid), 32'd0);
    mip[7] = 1'b1; ready = 1'b0;
    tick();
    chk("hs_was_xfer", 32'(valid), 32'd0);
    tick();
    chk("hs_rereq", 32'(valid), 32'd1);

    // Debug mode withdraws and blocks
    debug_mode = 1'b1;
    tick();
    chk("dbg_wd", 32'(valid), 32'd0);
    tick(); tick();
    chk("dbg_block", 32'(valid), 32'd0);
    chk("dbg_pend", 32'(pend), 32'd1);
    debug_mode = 1'b0;
    tick();
    chk("dbg_release", 32'(valid), 32'd1);

    // Reset during REQ
    rst = 1'b1;
    tick();
    chk("rreq_valid", 32'(valid), 32'd0);
    chk("rreq_cause", 32'(cause), 32'd0);
    chk("rreq_to_s",  32'(to_s),  32'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
